led_bank_arbiter: RTL and testbench

//  Time-slot arbiter sharing one LED bank between NUM_REQ pattern generators (scanner,

---
 rtl/led_arb_pkg.sv | 15 +
 rtl/led_bank_arbiter_if.sv | 24 ++
 rtl/led_tick_prescaler.sv | 24 ++
 rtl/led_bank_arbiter.sv | 142 ++++++++++++++
 tb/tb_led_bank_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/led_arb_pkg.sv
// Shared types and width helpers for the LED bank arbiter slice.
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    BLANK
  } arb_state_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Generator-side / arbiter-side signal bundle for the shared LED bank.
interface led_bank_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LED_W   = 8
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LED_W-1:0] pattern_in;
  logic [NUM_REQ-1:0]       grant;
  logic                     step_tick;
  logic [LED_W-1:0]         led_out;
  logic                     busy;

  modport master (
    output req, pattern_in,
    input  grant, step_tick, led_out, busy
  );

  modport slave (
    input  req, pattern_in,
    output grant, step_tick, led_out, busy
  );

endinterface

// File: rtl/led_tick_prescaler.sv
// Free-running divider: tick is high for one clk out of every TICK_DIV.
module led_tick_prescaler
  import led_arb_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned PW = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || cnt == LAST) cnt <= '0;
    else                    cnt <= cnt + PW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_bank_arbiter.sv
// Time-slot arbiter sharing one LED bank between NUM_REQ pattern generators.
// Define LED_ARB_PRIORITY_EN for fixed lowest-index-wins arbitration instead of round-robin.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LED_W      = 8,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned SLOT_TICKS = 16,
  parameter int unsigned GAP_TICKS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  led_bank_arbiter_if.slave   bus
);

  localparam int unsigned IW = cnt_w(NUM_REQ);
  localparam int unsigned SW = cnt_w(SLOT_TICKS);
  localparam int unsigned GW = cnt_w(GAP_TICKS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_TICKS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               step_q, step_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               busy_q, busy_d;
  logic               tick;

  led_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // owner_q doubles as the round-robin pointer; ptr is only a fallback in priority mode.
  function automatic logic [IW-1:0] pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] ptr);
    logic [IW-1:0] win;
    logic          found;
    int unsigned   idx;
    win   = ptr;
    found = 1'b0;
`ifdef LED_ARB_PRIORITY_EN
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = i;
      if (!found && r[IW'(idx)]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
`else
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && r[IW'(idx)]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
`endif
    return win;
  endfunction

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    slot_d  = slot_q;
    gap_d   = gap_q;
    grant_d = '0;
    step_d  = 1'b0;
    led_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d = pick(bus.req, owner_q);
          grant_d = NUM_REQ'(1) << owner_d;
          slot_d  = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        // A dropped request wins over a coincident end-of-slot tick: no step is issued.
        if (!bus.req[owner_q]) begin
          state_d = BLANK;
          gap_d   = '0;
        end else begin
          grant_d = NUM_REQ'(1) << owner_q;
          led_d   = bus.pattern_in[owner_q*LED_W +: LED_W];
          if (tick) begin
            step_d = 1'b1;
            if (slot_q == SLOT_LAST) begin
              state_d = BLANK;
              gap_d   = '0;
              grant_d = '0;
              led_d   = '0;
            end else begin
              slot_d = slot_q + SW'(1);
            end
          end
        end
      end
      BLANK: begin
        if (tick) begin
          if (gap_q == GAP_LAST) state_d = IDLE;
          else                   gap_d   = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= IW'(NUM_REQ - 1);
      slot_q  <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      step_q  <= 1'b0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      slot_q  <= slot_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      step_q  <= step_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.step_tick = step_q;
  assign bus.led_out   = led_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter: expected slots queued by stimulus, checked by a monitor.
module tb_led_bank_arbiter;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] led;
    int         steps;    // -1: slot is expected to be cut short by reset
    int         lat;      // -1: no latency check
    bit         chk_gap;  // previous slot ended on a tick -> exactly 5 blank samples
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  exp_t q[$];
  exp_t cur;
  bit   open = 0;
  bit   shape_bad;
  int   steps_seen = 0;
  int   gap_len = 0;
  int   rel_cnt = 0;
  bit   rst_s = 1'b1;
  logic [3:0] prev_grant = '0;

  led_bank_arbiter_if #(.NUM_REQ(4), .LED_W(8)) bus ();

  led_bank_arbiter #(
    .NUM_REQ(4), .LED_W(8), .TICK_DIV(4), .SLOT_TICKS(3), .GAP_TICKS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input bit ok, input int act, input int req_v);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h @%0t", nm, act, req_v, $time);
    end
  endfunction

  always @(posedge clk) begin
    rst_s = rst;
    rel_cnt = rst ? 0 : rel_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst_s) begin
      chk("reset_outputs",
          bus.grant == 4'b0 && bus.led_out == 8'h00 && bus.busy == 1'b0 && bus.step_tick == 1'b0,
          {bus.busy, bus.step_tick, bus.grant, bus.led_out}, 0);
      if (open && cur.steps >= 0) chk("slot_aborted", 1'b0, cur.grant, 0);
      open = 0;
      steps_seen = 0;
      gap_len = 0;
    end else begin
      if (bus.step_tick) steps_seen++;
      if (bus.grant != 4'b0 && prev_grant == 4'b0) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", 1'b0, bus.grant, 0);
          open = 0;
        end else begin
          cur = q.pop_front();
          chk("grant_order", bus.grant == cur.grant, bus.grant, cur.grant);
          if (cur.lat >= 0) chk("grant_latency", rel_cnt == cur.lat, rel_cnt, cur.lat);
          if (cur.chk_gap)  chk("gap_length", gap_len == 5, gap_len, 5);
          open = 1;
        end
        steps_seen = 0;
        shape_bad = (bus.led_out != 8'h00) || !bus.busy;
      end else if (bus.grant != 4'b0) begin
        if (bus.grant != prev_grant || bus.led_out != cur.led || !bus.busy) shape_bad = 1;
      end else if (prev_grant != 4'b0) begin
        if (open) begin
          if (cur.steps >= 0) chk("step_count", steps_seen == cur.steps, steps_seen, cur.steps);
          chk("slot_shape", !shape_bad && bus.led_out == 8'h00 && bus.busy,
              {shape_bad, bus.busy, bus.led_out}, {1'b0, 1'b1, 8'h00});
        end
        open = 0;
        gap_len = 1;
      end else begin
        gap_len++;
      end
    end
    prev_grant = bus.grant;
  end

  function automatic exp_t mk(input logic [3:0] g, input int steps, input int lat, input bit gapc);
    exp_t e;
    e.grant = g;
    e.steps = steps;
    e.lat   = lat;
    e.chk_gap = gapc;
    case (g)
      4'b0001: e.led = 8'h11;
      4'b0010: e.led = 8'h22;
      4'b0100: e.led = 8'h33;
      default: e.led = 8'h44;
    endcase
    return e;
  endfunction

  // rst rises first so the new request cannot be granted before reset takes effect.
  task automatic apply_reset(input int n, input logic [3:0] r);
    @(posedge clk); #2;
    rst = 1'b1;
    bus.req = r;
    repeat (n) begin @(posedge clk); #2; end
    rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk); #2;
      if (q.size() == 0 && !open) done = 1;
    end
    if (!done) chk({nm, "_timeout"}, 1'b0, q.size(), 0);
    bus.req = 4'b0;
    q.delete();
    repeat (12) @(posedge clk);
  endtask

  task automatic wait_cond_grant(input logic [3:0] g, input bit need_step, input string nm);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #2;
      if (bus.grant == g && (!need_step || bus.step_tick)) done = 1;
    end
    if (!done) chk(nm, 1'b0, bus.grant, g);
  endtask

  initial begin
    bus.req = 4'b0;
    for (int i = 0; i < 4; i++) bus.pattern_in[i*8 +: 8] = 8'(8'h11 * (i + 1));

    // Reset held with all requests up, then full round-robin rotation.
    q.push_back(mk(4'b0001, 3, 1, 0));
    q.push_back(mk(4'b0010, 3, -1, 1));
    q.push_back(mk(4'b0100, 3, -1, 1));
    q.push_back(mk(4'b1000, 3, -1, 1));
    q.push_back(mk(4'b0001, 3, -1, 1));
    apply_reset(5, 4'b1111);
    drain("rotation");

    // Lone requester keeps regaining the bank.
    q.push_back(mk(4'b0100, 3, 1, 0));
    q.push_back(mk(4'b0100, 3, -1, 1));
    q.push_back(mk(4'b0100, 3, -1, 1));
    apply_reset(2, 4'b0100);
    drain("single");

    // Owner 0 drops its request after the first step.
    q.push_back(mk(4'b0001, 1, 1, 0));
    q.push_back(mk(4'b0010, 3, -1, 0));
    apply_reset(2, 4'b0011);
    wait_cond_grant(4'b0001, 1, "first_step_wait");
    bus.req = 4'b0010;
    drain("early_drop");

    // Reset in the middle of the second owner's slot.
    q.push_back(mk(4'b0001, 3, 1, 0));
    q.push_back(mk(4'b0010, -1, -1, 1));
    apply_reset(2, 4'b1111);
    wait_cond_grant(4'b0010, 0, "second_owner_wait");
    repeat (2) @(posedge clk);
    q.push_back(mk(4'b0001, 3, 1, 0));
    apply_reset(3, 4'b1111);
    drain("mid_slot_reset");

    // Two requesters; ordering depends on arbitration mode.
`ifdef LED_ARB_PRIORITY_EN
    q.push_back(mk(4'b0010, 3, 1, 0));
    q.push_back(mk(4'b0010, 3, -1, 1));
    q.push_back(mk(4'b0010, 3, -1, 1));
`else
    q.push_back(mk(4'b0010, 3, 1, 0));
    q.push_back(mk(4'b1000, 3, -1, 1));
    q.push_back(mk(4'b0010, 3, -1, 1));
`endif
    apply_reset(2, 4'b1010);
    drain("pair");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
